// File: rtl/seg_share_ctrl.sv
// Shared 4-digit seven-segment controller: round-robin grant of three value sources,
// serial double-dabble BCD conversion, dwell timing and digit scan. Optional: LEAD_ZERO_BLANK_EN.
module seg_share_ctrl #(
    parameter int DWELL = 4,
    parameter int VAL_W = 14
) (
    input  logic             clk_mid,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [VAL_W-1:0] val0,
    input  logic [VAL_W-1:0] val1,
    input  logic [VAL_W-1:0] val2,
    input  logic             tick,
    output logic [2:0]       gnt,
    output logic [15:0]      bcd,
    output logic             bcd_valid,
    output logic [3:0]       an,
    output logic [3:0]       digit
);

    typedef enum logic [1:0] {IDLE, LOAD, CONV, SHOW} state_t;

    localparam logic [3:0] DWELL_C   = 4'(DWELL);
    localparam logic [3:0] LAST_STEP = 4'd13;

    state_t           state_r;
    logic [29:0]      sr_r;
    logic [3:0]       step_r;
    logic [3:0]       dwell_r;
    logic [1:0]       ptr_r;
    logic [3:0]       scan_r;
    logic [1:0]       pick_s;
    logic [1:0]       ptr_next_s;
    logic [VAL_W-1:0] sel_val_s;
    logic [29:0]      dd_next_s;
    logic             held_s;

    // Clamp a source value to the largest number four BCD digits can hold.
    function automatic logic [13:0] sat_val(input logic [VAL_W-1:0] v);
        if (v > VAL_W'(9999)) begin
            return 14'd9999;
        end else begin
            return 14'(v);
        end
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [29:0] dd_step(input logic [29:0] s);
        logic [29:0] t;
        t = s;
        for (int n = 0; n < 4; n++) begin
            if (t[14 + 4*n +: 4] >= 4'd5) begin
                t[14 + 4*n +: 4] = t[14 + 4*n +: 4] + 4'd3;
            end else begin
                t[14 + 4*n +: 4] = t[14 + 4*n +: 4];
            end
        end
        return t << 1;
    endfunction

    // First requesting index at or after ptr, wrapping modulo 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] idx;
        logic [1:0] res;
        res = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = 3'(p) + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end else begin
                idx = idx;
            end
            if (r[idx[1:0]]) begin
                res = idx[1:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Grant selection, granted-source mux and the next conversion step.
    always_comb begin
        pick_s     = rr_pick(req, ptr_r);
        ptr_next_s = (pick_s == 2'd2) ? 2'd0 : pick_s + 2'd1;
        held_s     = |(req & gnt);
        dd_next_s  = dd_step(sr_r);
        case (gnt)
            3'b001:  sel_val_s = val0;
            3'b010:  sel_val_s = val1;
            3'b100:  sel_val_s = val2;
            default: sel_val_s = {VAL_W{1'b0}};
        endcase
    end

    // Main FSM; a dropped request in any busy state aborts without touching bcd.
    always_ff @(posedge clk_mid or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            gnt       <= 3'b000;
            bcd       <= 16'h0000;
            bcd_valid <= 1'b0;
            sr_r      <= 30'd0;
            step_r    <= 4'd0;
            dwell_r   <= 4'd0;
            ptr_r     <= 2'd0;
        end else begin
            bcd_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        gnt     <= 3'b001 << pick_s;
                        ptr_r   <= ptr_next_s;
                        state_r <= LOAD;
                    end else begin
                        gnt     <= 3'b000;
                    end
                end
                LOAD: begin
                    if (!held_s) begin
                        gnt     <= 3'b000;
                        state_r <= IDLE;
                    end else begin
                        sr_r    <= {16'h0000, sat_val(sel_val_s)};
                        step_r  <= 4'd0;
                        state_r <= CONV;
                    end
                end
                CONV: begin
                    if (!held_s) begin
                        gnt     <= 3'b000;
                        state_r <= IDLE;
                    end else begin
                        sr_r <= dd_next_s;
                        if (step_r == LAST_STEP) begin
                            bcd       <= dd_next_s[29:14];
                            bcd_valid <= 1'b1;
                            dwell_r   <= 4'd0;
                            state_r   <= SHOW;
                        end else begin
                            step_r    <= step_r + 4'd1;
                        end
                    end
                end
                SHOW: begin
                    if (!held_s) begin
                        gnt     <= 3'b000;
                        state_r <= IDLE;
                    end else if (tick) begin
                        if (dwell_r + 4'd1 == DWELL_C) begin
                            gnt     <= 3'b000;
                            state_r <= IDLE;
                        end else begin
                            dwell_r <= dwell_r + 4'd1;
                        end
                    end else begin
                        dwell_r <= dwell_r;
                    end
                end
                default: begin
                    gnt     <= 3'b000;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Free-running digit scanner, ones digit first.
    always_ff @(posedge clk_mid or posedge rst) begin
        if (rst) begin
            scan_r <= 4'b1111;
        end else begin
            case (scan_r)
                4'b1110: scan_r <= 4'b1101;
                4'b1101: scan_r <= 4'b1011;
                4'b1011: scan_r <= 4'b0111;
                default: scan_r <= 4'b1110;
            endcase
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic blank_th_s;
    logic blank_hu_s;
    logic blank_te_s;

    // Blank leading zero digits; the ones digit always stays lit.
    always_comb begin
        blank_th_s = (bcd[15:12] == 4'd0);
        blank_hu_s = blank_th_s && (bcd[11:8] == 4'd0);
        blank_te_s = blank_hu_s && (bcd[7:4] == 4'd0);
        an         = scan_r | {blank_th_s, blank_hu_s, blank_te_s, 1'b0};
    end
`else
    // All four digits scan unconditionally.
    always_comb begin
        an = scan_r;
    end
`endif

    // Nibble for the enabled digit; dark when no digit is enabled.
    always_comb begin
        case (an)
            4'b1110: digit = bcd[3:0];
            4'b1101: digit = bcd[7:4];
            4'b1011: digit = bcd[11:8];
            4'b0111: digit = bcd[15:12];
            default: digit = 4'd0;
        endcase
    end

endmodule

// File: tb/tb_seg_share_ctrl.sv
// Scoreboard bench for seg_share_ctrl (DWELL=2): expected bcd words are queued at
// stimulus time and popped by a monitor on every bcd_valid pulse.
module tb_seg_share_ctrl;

    logic        clk_mid;
    logic        rst;
    logic [2:0]  req;
    logic [13:0] val0, val1, val2;
    logic        tick;
    logic [2:0]  gnt;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic [3:0]  an;
    logic [3:0]  digit;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    seg_share_ctrl #(.DWELL(2), .VAL_W(14)) dut (
        .clk_mid(clk_mid), .rst(rst), .req(req),
        .val0(val0), .val1(val1), .val2(val2), .tick(tick),
        .gnt(gnt), .bcd(bcd), .bcd_valid(bcd_valid), .an(an), .digit(digit)
    );

    initial clk_mid = 1'b0;
    always #5 clk_mid = ~clk_mid;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_mid);
        #1;
    endtask

    task automatic wait_gnt(input string nm);
        int k = 0;
        while (gnt == 3'b000 && k < 20) begin
            step();
            k++;
        end
        check(nm, {31'd0, gnt != 3'b000}, 32'd1);
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (!bcd_valid && k < 40) begin
            step();
            k++;
        end
        check(nm, {31'd0, bcd_valid}, 32'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk_mid) begin
        if (!rst && bcd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("bcd", {16'd0, bcd}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       early;
        logic [3:0] lit;
        logic [2:0] exp_g[4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;

        rst = 1'b1; req = 3'b000; tick = 1'b0;
        val0 = 14'd0; val1 = 14'd0; val2 = 14'd0;
        step(); step();
        check("rst_gnt", {29'd0, gnt}, 32'd0);
        check("rst_bcd", {16'd0, bcd}, 32'd0);
        check("rst_valid", {31'd0, bcd_valid}, 32'd0);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_digit", {28'd0, digit}, 32'd0);
        rst = 1'b0;
        step();
        check("an_after_rst", {28'd0, an}, 32'hE);

        // Basic conversion, exact latency, and input change after LOAD
        val0 = 14'd1234; req = 3'b001; exp_q.push_back(16'h1234);
        step();
        check("gnt_first", {29'd0, gnt}, 32'd1);
        step();
        val0 = 14'd9;
        early = 1'b0;
        repeat (13) begin
            step();
            if (bcd_valid) early = 1'b1;
        end
        step();
        check("valid_latency", {31'd0, bcd_valid}, 32'd1);
        check("valid_early", {31'd0, early}, 32'd0);
        begin
            int k = 0;
            while (an != 4'b1110 && k < 8) begin step(); k++; end
        end
        check("digit_ones", {28'd0, digit}, 32'd4);
        req = 3'b000;
        step();
        check("gnt_drop_show", {29'd0, gnt}, 32'd0);
        step();

        // Saturation through requester 1
        val1 = 14'd12000; req = 3'b010; exp_q.push_back(16'h9999);
        step();
        check("gnt_sat", {29'd0, gnt}, 32'd2);
        wait_valid("sat_valid");
        req = 3'b000;
        step(); step();

        // Round robin from a fresh pointer, DWELL=2, 000 gap between grants
        rst = 1'b1; step(); rst = 1'b0; step();
        val0 = 14'd1234; val2 = 14'd56;
        exp_q.push_back(16'h1234); exp_q.push_back(16'h9999);
        exp_q.push_back(16'h0056); exp_q.push_back(16'h1234);
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_gnt("rr_wait");
            check("rr_gnt", {29'd0, gnt}, {29'd0, exp_g[i]});
            if (i == 0) begin
                tick = 1'b1; step(); tick = 1'b0;
            end
            wait_valid("rr_valid");
            tick = 1'b1; step(); tick = 1'b0;
            check("rr_hold_1tick", {29'd0, gnt}, {29'd0, exp_g[i]});
            tick = 1'b1; step(); tick = 1'b0;
            check("rr_gap", {29'd0, gnt}, 32'd0);
        end
        req = 3'b000;
        step(); step();

        // Abort during CONV: no pulse, bcd kept
        val0 = 14'd4321; req = 3'b001;
        wait_gnt("abort_wait");
        check("abort_gnt", {29'd0, gnt}, 32'd1);
        repeat (5) step();
        req = 3'b000;
        step();
        check("abort_gnt_clear", {29'd0, gnt}, 32'd0);
        early = 1'b0;
        repeat (20) begin
            step();
            if (bcd_valid) early = 1'b1;
        end
        check("abort_no_valid", {31'd0, early}, 32'd0);
        check("abort_bcd_kept", {16'd0, bcd}, 32'h1234);

        // Reset during CONV
        req = 3'b001;
        wait_gnt("rstconv_wait");
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("rstconv_bcd", {16'd0, bcd}, 32'd0);
        check("rstconv_an", {28'd0, an}, 32'hF);
        check("rstconv_gnt", {29'd0, gnt}, 32'd0);
        req = 3'b000;
        step();
        rst = 1'b0;
        early = 1'b0;
        repeat (20) begin
            step();
            if (bcd_valid) early = 1'b1;
        end
        check("rstconv_no_valid", {31'd0, early}, 32'd0);

        // Digit scan with a small value
        val0 = 14'd7; req = 3'b001; exp_q.push_back(16'h0007);
        wait_gnt("scan_wait");
        wait_valid("scan_valid");
        lit = 4'b0000;
        repeat (8) begin
            step();
            lit = lit | ~an;
            if (an == 4'b1110) check("scan_ones", {28'd0, digit}, 32'd7);
            else if (an == 4'b1111) check("scan_dark", {28'd0, digit}, 32'd0);
            else check("scan_upper", {28'd0, digit}, 32'd0);
        end
`ifdef LEAD_ZERO_BLANK_EN
        check("scan_lit", {28'd0, lit}, 32'h1);
`else
        check("scan_lit", {28'd0, lit}, 32'hF);
`endif
        req = 3'b000;
        step(); step();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
